// File: rtl/count_sequencer_pkg.sv
// Shared definitions for the BCD display count sequencer.
// Holds the FSM state type, the default timing and digit-limit values,
// and the width of one BCD digit.
package count_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned DIGIT_W             = 4;
  localparam int unsigned DEF_TICK_PERIOD     = 5_000_000;
  localparam int unsigned DEF_TICK_W          = 23;
  localparam int unsigned DEF_UNITS_LIMIT     = 10;
  localparam int unsigned DEF_TENS_LIMIT      = 10;
  localparam logic [7:0]  DEF_END_COUNT       = 8'h99;

endpackage

// File: rtl/count_sequencer_bcd_digit_counter.sv
// One BCD digit of the display counter.
// Ports:
//   clk_in  clock
//   rst_n   asynchronous reset, active low
//   en      advance the digit by one this cycle
//   clr     force the digit to zero (wins over en)
//   q       current digit value
//   wrap    digit sits at LIMIT-1, so an enabled step returns it to zero
module bcd_digit_counter
  import count_sequencer_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_UNITS_LIMIT
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  output logic [DIGIT_W-1:0] q,
  output logic               wrap
);

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(LIMIT - 1);

  logic [DIGIT_W-1:0] q_q;
  logic [DIGIT_W-1:0] q_d;

  assign wrap = (q_q == DIGIT_MAX);
  assign q    = q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = wrap ? '0 : q_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Run/stop sequencer for the two-digit BCD display counter.
// A prescaler running only in RUN produces a one-cycle tick every TICK_PERIOD
// run cycles; each tick steps the units digit, which cascades into tens.
// Ports:
//   clk_in     board clock
//   rst_n      asynchronous reset, active low
//   start      pulse: run / resume
//   stop       pulse: pause
//   clear      pulse: zero the count and return to IDLE (highest priority)
//   mode_wrap  1: wrap END_COUNT to 0 and keep running; 0: halt in DONE
//   count      {tens, units} BCD value
//   running    high while in RUN
//   done       high while in DONE
//   tick       one-cycle pulse per increment
//   carry      with tick when the units digit is about to wrap
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int unsigned TICK_PERIOD = DEF_TICK_PERIOD,
  parameter int unsigned TICK_W      = DEF_TICK_W,
  parameter int unsigned UNITS_LIMIT = DEF_UNITS_LIMIT,
  parameter int unsigned TENS_LIMIT  = DEF_TENS_LIMIT,
  parameter logic [7:0]  END_COUNT   = DEF_END_COUNT
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       mode_wrap,
  output logic [7:0] count,
  output logic       running,
  output logic       done,
  output logic       tick,
  output logic       carry
);

  localparam logic [TICK_W-1:0] PRESC_LAST = TICK_W'(TICK_PERIOD - 1);

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   presc_q, presc_d;
  logic                tick_q, tick_d;
  logic                carry_q, carry_d;
  logic                running_q, running_d;
  logic                done_q, done_d;

  logic [DIGIT_W-1:0]  units_q;
  logic [DIGIT_W-1:0]  tens_q;
  logic                units_wrap;
  logic                tens_wrap;

  logic                at_end;
  logic                halt;
  logic                digit_clr;
  logic                units_en;
  logic                tens_en;

  // The registered tick is consumed on the edge that ends its high cycle.
  // At the terminal value that edge either halts (count held) or forces
  // both digits to zero, so END_COUNT need not coincide with a natural wrap.
  assign at_end    = ({tens_q, units_q} == END_COUNT);
  assign halt      = tick_q & at_end & ~mode_wrap;
  assign digit_clr = clear | (tick_q & at_end & mode_wrap);
  assign units_en  = tick_q & ~halt;
  assign tens_en   = units_en & units_wrap;

  bcd_digit_counter #(
    .LIMIT (UNITS_LIMIT)
  ) u_units (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (units_en),
    .clr    (digit_clr),
    .q      (units_q),
    .wrap   (units_wrap)
  );

  bcd_digit_counter #(
    .LIMIT (TENS_LIMIT)
  ) u_tens (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (tens_en),
    .clr    (digit_clr),
    .q      (tens_q),
    .wrap   (tens_wrap)
  );

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (halt) begin
      state_d = ST_DONE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (start)          state_d = ST_RUN;
        ST_RUN:   if (stop)           state_d = ST_PAUSE;
        ST_PAUSE: if (start && !stop) state_d = ST_RUN;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Prescaler counts every cycle spent in RUN, so a pause keeps the partial
  // period and resume continues exactly where it left off.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (clear || state_q == ST_IDLE) begin
      presc_d = '0;
    end else if (state_q == ST_RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_comb begin
    carry_d   = tick_d & units_wrap;
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      carry_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      carry_q   <= carry_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign count   = {tens_q, units_q};
  assign running = running_q;
  assign done    = done_q;
  assign tick    = tick_q;
  assign carry   = carry_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer with TICK_PERIOD=4, limits 10, END_COUNT=8'h12.
module tb_count_sequencer;

  localparam int         P     = 4;
  localparam int         UL    = 10;
  localparam int         TL    = 10;
  localparam logic [7:0] END_C = 8'h12;
  localparam int         ENDV  = int'(END_C[7:4]) * UL + int'(END_C[3:0]);

  localparam int MI = 0;
  localparam int MR = 1;
  localparam int MP = 2;
  localparam int MD = 3;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic       stop   = 1'b0;
  logic       clear  = 1'b0;
  logic       mode_wrap = 1'b0;
  logic [7:0] count;
  logic       running;
  logic       done;
  logic       tick;
  logic       carry;

  int checks = 0;
  int errors = 0;
  int n_tick = 0;
  int n_carry = 0;
  int n_done = 0;

  always #5 clk_in = ~clk_in;

  count_sequencer #(
    .TICK_PERIOD (P),
    .TICK_W      (3),
    .UNITS_LIMIT (UL),
    .TENS_LIMIT  (TL),
    .END_COUNT   (END_C)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .mode_wrap (mode_wrap),
    .count     (count),
    .running   (running),
    .done      (done),
    .tick      (tick),
    .carry     (carry)
  );

  // Reference model: run-cycle counter, integer count value, abstract mode.
  int m_st, m_runs, m_val;
  bit m_tick, m_carry;

  function automatic logic [7:0] bcd_of(input int v);
    logic [3:0] t, u;
    t = 4'(v / UL);
    u = 4'(v % UL);
    return {t, u};
  endfunction

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= MI; m_runs <= 0; m_val <= 0; m_tick <= 0; m_carry <= 0;
    end else if (clear) begin
      m_st <= MI; m_runs <= 0; m_val <= 0; m_tick <= 0; m_carry <= 0;
    end else begin
      m_runs  <= (m_st == MR) ? m_runs + 1 : m_runs;
      m_tick  <= (m_st == MR) && ((m_runs + 1) % P == 0);
      m_carry <= (m_st == MR) && ((m_runs + 1) % P == 0) && (m_val % UL == UL - 1);
      if (m_tick && m_val == ENDV && !mode_wrap) m_st <= MD;
      else if (m_st == MI && start) m_st <= MR;
      else if (m_st == MR && stop) m_st <= MP;
      else if (m_st == MP && start && !stop) m_st <= MR;
      if (m_tick) begin
        if (m_val == ENDV) m_val <= mode_wrap ? 0 : m_val;
        else m_val <= (m_val + 1) % (UL * TL);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    if (rst_n) begin
      chk("model_count",   32'(count),   32'(bcd_of(m_val)));
      chk("model_running", 32'(running), 32'(m_st == MR));
      chk("model_done",    32'(done),    32'(m_st == MD));
      chk("model_tick",    32'(tick),    32'(m_tick));
      chk("model_carry",   32'(carry),   32'(m_carry));
      if (tick)  n_tick++;
      if (carry) n_carry++;
      if (done)  n_done++;
    end
  end

  task automatic pulse(input logic s, input logic p, input logic c);
    start = s; stop = p; clear = c;
    @(posedge clk_in); #1;
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_in); #1;
    end
  endtask

  int t0, c0, d0;

  initial begin
    // reset, no clock edge yet
    #2;
    chk("rst_count", 32'(count), 32'h00);
    chk("rst_running", 32'(running), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_carry", 32'(carry), 0);
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    cyc(2);

    // 1: ten ticks from start
    t0 = n_tick; c0 = n_carry;
    pulse(1, 0, 0);
    chk("t1_running", 32'(running), 1);
    cyc(41);
    chk("t1_count", 32'(count), 32'h10);
    chk("t1_ticks", 32'(n_tick - t0), 10);
    chk("t1_carries", 32'(n_carry - c0), 1);
    pulse(0, 0, 1);
    chk("t1_clr_count", 32'(count), 32'h00);
    chk("t1_clr_running", 32'(running), 0);

    // 2: pause keeps partial period
    pulse(1, 0, 0);
    cyc(13);
    pulse(0, 1, 0);
    chk("t2_pause_running", 32'(running), 0);
    t0 = n_tick;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("t2_pause_count", 32'(count), 32'h03);
    end
    chk("t2_pause_ticks", 32'(n_tick - t0), 0);
    pulse(1, 0, 0);
    chk("t2_resume_running", 32'(running), 1);
    chk("t2_resume_tick0", 32'(tick), 0);
    cyc(1);
    chk("t2_resume_tick1", 32'(tick), 0);
    cyc(1);
    chk("t2_resume_tick2", 32'(tick), 1);
    cyc(1);
    chk("t2_count4", 32'(count), 32'h04);
    pulse(0, 0, 1);

    // 3: halt at END_COUNT
    mode_wrap = 1'b0;
    pulse(1, 0, 0);
    cyc(60);
    chk("t3_count", 32'(count), 32'h12);
    chk("t3_done", 32'(done), 1);
    chk("t3_running", 32'(running), 0);
    t0 = n_tick;
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    cyc(8);
    chk("t3_ign_done", 32'(done), 1);
    chk("t3_ign_count", 32'(count), 32'h12);
    chk("t3_ign_ticks", 32'(n_tick - t0), 0);
    pulse(0, 0, 1);
    chk("t3_clr_count", 32'(count), 32'h00);
    chk("t3_clr_done", 32'(done), 0);
    chk("t3_clr_running", 32'(running), 0);

    // 4: wrap at END_COUNT
    mode_wrap = 1'b1;
    d0 = n_done;
    pulse(1, 0, 0);
    cyc(50);
    chk("t4_end", 32'(count), 32'h12);
    cyc(3);
    chk("t4_wrapped", 32'(count), 32'h00);
    chk("t4_running", 32'(running), 1);
    cyc(10);
    chk("t4_after", 32'(count), 32'h02);
    chk("t4_no_done", 32'(n_done - d0), 0);
    mode_wrap = 1'b0;
    pulse(0, 0, 1);

    // 5: command priority and clear on a tick cycle
    pulse(1, 0, 0);
    cyc(5);
    chk("t5_count1", 32'(count), 32'h01);
    pulse(1, 0, 1);
    chk("t5_clrstart_count", 32'(count), 32'h00);
    chk("t5_clrstart_running", 32'(running), 0);
    pulse(1, 0, 0);
    cyc(3);
    pulse(1, 1, 0);
    chk("t5_startstop_run", 32'(running), 0);
    chk("t5_startstop_done", 32'(done), 0);
    pulse(1, 1, 0);
    chk("t5_pause_startstop", 32'(running), 0);
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    cyc(4);
    chk("t5_tick_hi", 32'(tick), 1);
    pulse(0, 0, 1);
    chk("t5_tickclr_count", 32'(count), 32'h00);
    chk("t5_tickclr_tick", 32'(tick), 0);
    chk("t5_tickclr_running", 32'(running), 0);

    // 6: asynchronous reset mid-run
    pulse(1, 0, 0);
    cyc(10);
    chk("t6_pre_count", 32'(count), 32'h02);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_count", 32'(count), 32'h00);
    chk("t6_rst_running", 32'(running), 0);
    chk("t6_rst_tick", 32'(tick), 0);
    cyc(2);
    rst_n = 1'b1;
    t0 = n_tick;
    cyc(12);
    chk("t6_idle_ticks", 32'(n_tick - t0), 0);
    chk("t6_idle_count", 32'(count), 32'h00);
    chk("t6_idle_running", 32'(running), 0);
    pulse(1, 0, 0);
    cyc(5);
    chk("t6_run_ticks", 32'(n_tick - t0), 1);
    chk("t6_run_count", 32'(count), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
